console_arbiter: RTL and testbench

//  Shares the single simulation console (char-out + sim-halt registers) between NumReq bus masters.

---
 rtl/console_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_console_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/console_arbiter.sv
// Shares one simulation console among several bus masters. Text is buffered per requester and
// whole lines are forwarded without interleaving; a halt request is forwarded after all text drains.
module console_arbiter #(
  parameter int          NumReq      = 2,
  parameter int          FifoDepth   = 4,
  parameter int          LockTimeout = 64,
  parameter logic [7:0]  CharAddr    = 8'h04,
  parameter logic [7:0]  CtrlAddr    = 8'h08
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_i,
  input  logic [NumReq-1:0]           we_i,
  input  logic [NumReq*32-1:0]        addr_i,
  input  logic [NumReq*32-1:0]        wdata_i,
  output logic [NumReq-1:0]           gnt_o,
  output logic                        req_o,
  output logic                        we_o,
  output logic [31:0]                 addr_o,
  output logic [31:0]                 wdata_o,
  output logic [$clog2(NumReq)-1:0]   owner_o,
  output logic                        busy_o
);

  localparam int IW = $clog2(NumReq);
  localparam int AW = $clog2(FifoDepth);
  localparam int TW = $clog2(LockTimeout);

  typedef enum logic [1:0] {IDLE, LOCKED, FLUSH, DONE} state_t;

  state_t               state;
  logic                 halt_pend;
  logic [IW-1:0]        rr;
  logic [IW-1:0]        owner;
  logic [TW-1:0]        timer;

  logic [NumReq-1:0]        char_wr;
  logic [NumReq-1:0]        ctrl_set;
  logic [NumReq-1:0]        push;
  logic [NumReq-1:0]        pop;
  logic [NumReq-1:0]        empty;
  logic [NumReq-1:0]        full;
  logic [NumReq-1:0][7:0]   head;
  logic [NumReq-1:0]        unused_hi;
  logic                     done;
  logic                     found;
  logic [IW-1:0]            winner;
  logic [IW:0]              scan;

  assign done = (state == DONE);

  genvar gi;
  generate
    for (gi = 0; gi < NumReq; gi++) begin : g_req
      logic [7:0]  mem [FifoDepth];
      logic [AW:0] wr_ptr;
      logic [AW:0] rd_ptr;

      assign char_wr[gi]  = req_i[gi] & we_i[gi] & (addr_i[32*gi +: 8] == CharAddr);
      assign ctrl_set[gi] = req_i[gi] & we_i[gi] & (addr_i[32*gi +: 8] == CtrlAddr) & wdata_i[32*gi];
      // Grant uses the current full flag, so a same-edge pop never makes room for a push.
      assign gnt_o[gi]    = req_i[gi] & ~(char_wr[gi] & full[gi] & ~done);
      assign push[gi]     = char_wr[gi] & ~full[gi] & ~done;
      assign unused_hi[gi] = ^{addr_i[32*gi+8 +: 24], wdata_i[32*gi+8 +: 24]};

      always_ff @(posedge clk_i) begin
        if (push[gi]) mem[wr_ptr[AW-1:0]] <= wdata_i[32*gi +: 8];
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end else begin
          if (push[gi]) wr_ptr <= wr_ptr + 1'b1;
          if (pop[gi])  rd_ptr <= rd_ptr + 1'b1;
        end
      end

      assign empty[gi] = (wr_ptr == rd_ptr);
      assign full[gi]  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      assign head[gi]  = mem[rd_ptr[AW-1:0]];
    end
  endgenerate

  function automatic logic [IW-1:0] rr_after(input logic [IW-1:0] k);
    return (k == IW'(NumReq - 1)) ? '0 : k + 1'b1;
  endfunction

  // First non-empty FIFO at or after the round-robin pointer.
  always_comb begin
    found  = 1'b0;
    winner = rr;
    scan   = '0;
    for (int i = 0; i < NumReq; i++) begin
      scan = {1'b0, rr} + (IW+1)'(i);
      if (scan >= (IW+1)'(NumReq)) scan = scan - (IW+1)'(NumReq);
      if (!found && !empty[scan[IW-1:0]]) begin
        found  = 1'b1;
        winner = scan[IW-1:0];
      end
    end
  end

  always_comb begin
    pop = '0;
    case (state)
      IDLE:    if (!halt_pend && found) pop[winner] = 1'b1;
      LOCKED:  if (!empty[owner]) pop[owner] = 1'b1;
      FLUSH:   if (found) pop[winner] = 1'b1;
      default: pop = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      halt_pend <= 1'b0;
      rr        <= '0;
      owner     <= '0;
      timer     <= '0;
      req_o     <= 1'b0;
      addr_o    <= '0;
      wdata_o   <= '0;
    end else begin
      req_o   <= 1'b0;
      addr_o  <= '0;
      wdata_o <= '0;
      if (|ctrl_set && !done) halt_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (halt_pend) begin
            state <= FLUSH;
          end else if (found) begin
            req_o   <= 1'b1;
            addr_o  <= {24'h0, CharAddr};
            wdata_o <= {24'h0, head[winner]};
            if (head[winner] == 8'h0A) begin
              rr <= rr_after(winner);
            end else begin
              state <= LOCKED;
              owner <= winner;
              timer <= '0;
            end
          end
        end
        LOCKED: begin
          if (!empty[owner]) begin
            req_o   <= 1'b1;
            addr_o  <= {24'h0, CharAddr};
            wdata_o <= {24'h0, head[owner]};
            timer   <= '0;
            if (head[owner] == 8'h0A) begin
              state <= IDLE;
              rr    <= rr_after(owner);
            end
          end else if (halt_pend) begin
            state <= FLUSH;
          end else if (timer == TW'(LockTimeout - 1)) begin
            state <= IDLE;
            rr    <= rr_after(owner);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        FLUSH: begin
          req_o <= 1'b1;
          if (found) begin
            addr_o  <= {24'h0, CharAddr};
            wdata_o <= {24'h0, head[winner]};
            rr      <= rr_after(winner);
          end else begin
            addr_o    <= {24'h0, CtrlAddr};
            wdata_o   <= 32'h1;
            halt_pend <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          halt_pend <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign we_o    = req_o;
  assign owner_o = owner;
  // The terminal halted state counts as quiet: nothing can be buffered or emitted there.
  assign busy_o  = (|(~empty)) | (state == LOCKED) | (state == FLUSH);

endmodule

// File: tb/tb_console_arbiter.sv
// Scoreboard bench for console_arbiter: expected console writes are queued at stimulus time and
// compared in order against writes captured from the console port.
module tb_console_arbiter;

  localparam int LT = 64;
  localparam logic [31:0] CHAR = 32'h04;
  localparam logic [31:0] CTRL = 32'h08;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  req_i = '0;
  logic [1:0]  we_i = '0;
  logic [63:0] addr_i = '0;
  logic [63:0] wdata_i = '0;
  logic [1:0]  gnt_o;
  logic        req_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic        owner_o;
  logic        busy_o;

  console_arbiter #(.NumReq(2), .FifoDepth(4), .LockTimeout(LT), .CharAddr(8'h04), .CtrlAddr(8'h08)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .owner_o(owner_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; logic owner; } obs_t;
  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic owner; bit chk_owner; } exp_t;

  obs_t obs_q[$];
  exp_t exp_q[$];
  int   cyc_log[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (rst_ni && req_o) obs_q.push_back('{cyc, we_o, addr_o, wdata_o, owner_o});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=before 500000", $time);
    $fatal(1, "watchdog");
  end

  task automatic push_char(input logic [7:0] c, input logic own, input bit chk);
    exp_q.push_back('{CHAR, {24'h0, c}, own, chk});
  endtask

  // Called at posedge+1; drives one cycle and returns the grant seen mid-cycle.
  task automatic drive_cycle(input logic [1:0] rq, input logic [1:0] w, input logic [31:0] a0,
                             input logic [31:0] d0, input logic [31:0] a1, input logic [31:0] d1,
                             output logic [1:0] g);
    req_i = rq; we_i = w; addr_i = {a1, a0}; wdata_i = {d1, d0};
    @(negedge clk_i);
    g = gnt_o;
    @(posedge clk_i); #1;
    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
  endtask

  task automatic write_hold(input int k, input logic [31:0] a, input logic [31:0] d, output int waited);
    bit granted;
    waited = 0;
    granted = 0;
    while (!granted && waited < 50) begin
      req_i[k] = 1'b1; we_i[k] = 1'b1; addr_i[32*k +: 32] = a; wdata_i[32*k +: 32] = d;
      @(negedge clk_i);
      granted = gnt_o[k];
      @(posedge clk_i); #1;
      if (!granted) waited++;
    end
    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic drain(input string tag);
    exp_t e;
    obs_t o;
    int waited;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      waited = 0;
      while (obs_q.size() == 0 && waited < 300) begin @(posedge clk_i); #1; waited++; end
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s timeout: no console write, required addr=%h data=%h", tag, e.addr, e.wdata);
        exp_q.delete();
        return;
      end
      o = obs_q.pop_front();
      cyc_log.push_back(o.cyc);
      $display("txn %s cyc=%0d we=%0b addr=%h data=%h owner=%0d", tag, o.cyc, o.we, o.addr, o.wdata, o.owner);
      if (o.addr !== e.addr || o.wdata !== e.wdata || o.we !== 1'b1) begin
        n_fail++;
        $display("FAIL %s write: got we=%0b addr=%h data=%h, required we=1 addr=%h data=%h",
                 tag, o.we, o.addr, o.wdata, e.addr, e.wdata);
      end
      if (e.chk_owner) begin
        n_checks++;
        if (o.owner !== e.owner) begin
          n_fail++;
          $display("FAIL %s owner: got %0d required %0d", tag, o.owner, e.owner);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle(2);
    n_checks++;
    if ({req_o, we_o, addr_o, wdata_o, owner_o, busy_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%0b addr=%h data=%h owner=%0d busy=%0b required all 0",
               req_o, addr_o, wdata_o, owner_o, busy_o);
    end
    n_checks++;
    if (gnt_o !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_gnt: got %b required 00", gnt_o);
    end
    rst_ni = 1'b1;
    idle(1);
  endtask

  task automatic test_lines();
    logic [1:0] g;
    logic [7:0] c0 [3];
    logic [7:0] c1 [3];
    c0 = '{8'h41, 8'h42, 8'h0A};
    c1 = '{8'h43, 8'h44, 8'h0A};
    for (int i = 0; i < 3; i++) begin
      drive_cycle(2'b11, 2'b11, CHAR, {24'h0, c0[i]}, CHAR, {24'h0, c1[i]}, g);
      n_checks++;
      if (g !== 2'b11) begin
        n_fail++;
        $display("FAIL lines_gnt[%0d]: got %b required 11", i, g);
      end
      if (i == 0) begin
        n_checks++;
        if (busy_o !== 1'b1) begin
          n_fail++;
          $display("FAIL lines_busy: got %0b required 1", busy_o);
        end
      end
    end
    for (int i = 0; i < 3; i++) push_char(c0[i], 1'b0, 1);
    for (int i = 0; i < 3; i++) push_char(c1[i], 1'b1, 1);
    drain("lines");
  endtask

  task automatic test_timeout();
    logic [1:0] g;
    cyc_log.delete();
    drive_cycle(2'b01, 2'b01, CHAR, 32'h58, 32'h0, 32'h0, g);
    push_char(8'h58, 1'b0, 1);
    drain("timeout_x");
    idle(5);
    drive_cycle(2'b10, 2'b10, 32'h0, 32'h0, CHAR, 32'h59, g);
    drive_cycle(2'b10, 2'b10, 32'h0, 32'h0, CHAR, 32'h0A, g);
    push_char(8'h59, 1'b1, 1);
    push_char(8'h0A, 1'b1, 1);
    drain("timeout_y");
    n_checks++;
    if (cyc_log.size() < 2) begin
      n_fail++;
      $display("FAIL timeout_delay: only %0d writes logged, required 2", cyc_log.size());
    end else if (cyc_log[1] - cyc_log[0] !== LT + 1) begin
      n_fail++;
      $display("FAIL timeout_delay: got %0d cycles X->Y required %0d", cyc_log[1] - cyc_log[0], LT + 1);
    end
  endtask

  task automatic test_full();
    logic [1:0] g;
    int waited;
    drive_cycle(2'b01, 2'b01, CHAR, 32'h50, 32'h0, 32'h0, g);
    push_char(8'h50, 1'b0, 1);
    for (int i = 1; i <= 4; i++) begin
      drive_cycle(2'b10, 2'b10, 32'h0, 32'h0, CHAR, 32'h30 + i, g);
      n_checks++;
      if (g !== 2'b10) begin
        n_fail++;
        $display("FAIL full_fill[%0d]: got gnt %b required 10", i, g);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(2'b10, 2'b10, 32'h0, 32'h0, CHAR, 32'h35, g);
      n_checks++;
      if (g !== 2'b00) begin
        n_fail++;
        $display("FAIL full_stall[%0d]: got gnt %b required 00", i, g);
      end
    end
    drive_cycle(2'b11, 2'b11, CHAR, 32'h0A, CHAR, 32'h35, g);
    n_checks++;
    if (g !== 2'b01) begin
      n_fail++;
      $display("FAIL full_release: got gnt %b required 01", g);
    end
    push_char(8'h0A, 1'b0, 1);
    write_hold(1, CHAR, 32'h35, waited);
    n_checks++;
    if (waited !== 2) begin
      n_fail++;
      $display("FAIL full_wait: got %0d stalled cycles required 2", waited);
    end
    write_hold(1, CHAR, 32'h0A, waited);
    for (int i = 1; i <= 5; i++) push_char(8'h30 + 8'(i), 1'b1, 1);
    push_char(8'h0A, 1'b1, 1);
    drain("full");
  endtask

  task automatic test_noeffect();
    logic [1:0] g;
    drive_cycle(2'b11, 2'b01, CTRL, 32'h0, CHAR, 32'h0, g);
    n_checks++;
    if (g !== 2'b11) begin
      n_fail++;
      $display("FAIL noeffect_gnt: got %b required 11", g);
    end
    drive_cycle(2'b01, 2'b01, 32'h10, 32'h55, 32'h0, 32'h0, g);
    n_checks++;
    if (g !== 2'b01) begin
      n_fail++;
      $display("FAIL noeffect_other_gnt: got %b required 01", g);
    end
    idle(10);
    n_checks++;
    if (obs_q.size() !== 0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL noeffect_quiet: got %0d writes busy=%0b required 0 writes busy=0", obs_q.size(), busy_o);
    end
  endtask

  task automatic test_halt();
    logic [1:0] g;
    drive_cycle(2'b01, 2'b01, CHAR, 32'h68, 32'h0, 32'h0, g);
    drive_cycle(2'b01, 2'b01, CHAR, 32'h69, 32'h0, 32'h0, g);
    drive_cycle(2'b01, 2'b01, CTRL, 32'h1, 32'h0, 32'h0, g);
    push_char(8'h68, 1'b0, 1);
    push_char(8'h69, 1'b0, 1);
    exp_q.push_back('{CTRL, 32'h1, 1'b0, 0});
    drain("halt");
    idle(2);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_busy: got %0b required 0", busy_o);
    end
    drive_cycle(2'b11, 2'b11, CHAR, 32'h7A, CTRL, 32'h1, g);
    n_checks++;
    if (g !== 2'b11) begin
      n_fail++;
      $display("FAIL halt_absorb_gnt: got %b required 11", g);
    end
    idle(20);
    n_checks++;
    if (obs_q.size() !== 0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_absorb: got %0d writes busy=%0b required 0 writes busy=0", obs_q.size(), busy_o);
    end
  endtask

  task automatic test_reset_midop();
    logic [1:0] g;
    rst_ni = 1'b0;
    idle(2);
    rst_ni = 1'b1;
    idle(1);
    obs_q.delete();
    drive_cycle(2'b01, 2'b01, CHAR, 32'h4C, 32'h0, 32'h0, g);
    push_char(8'h4C, 1'b0, 1);
    drain("midop_lock");
    for (int i = 0; i < 3; i++) drive_cycle(2'b10, 2'b10, 32'h0, 32'h0, CHAR, 32'h61 + i, g);
    drive_cycle(2'b01, 2'b01, CTRL, 32'h1, 32'h0, 32'h0, g);
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({req_o, addr_o, wdata_o, owner_o, busy_o} !== '0) begin
      n_fail++;
      $display("FAIL midop_reset: got req=%0b addr=%h data=%h owner=%0d busy=%0b required all 0",
               req_o, addr_o, wdata_o, owner_o, busy_o);
    end
    idle(2);
    rst_ni = 1'b1;
    idle(100);
    n_checks++;
    if (obs_q.size() !== 0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_after: got %0d writes busy=%0b required 0 writes busy=0", obs_q.size(), busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_lines();
    test_timeout();
    test_full();
    test_noeffect();
    test_halt();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
